game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter DEATH_FRAMES, default 60, frames spent in DYING before OVER (legal 1..255).
REQ-002 SHALL have parameter SPAWN_FRAMES, default 120, frames between successive asteroid-slot enables (legal 1..255).
REQ-003 SHALL have port clk  input  1  25 MHz pixel clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn  input  4  {downbtn, upbtn, rightbtn, leftbtn}, level, already synchronous to clk.
REQ-006 SHALL have port debug  input  1  level; forces return to START.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse at start of each video frame.
REQ-008 SHALL have port collide_px  input  1  dino layer overlaps an obstacle layer at the current pixel.
REQ-009 SHALL have port game_state  output  2  START=0, PLAY=1, OVER=2, DYING=3.
REQ-010 SHALL have port halt  output  1  freezes movement, score and asteroid counters.
REQ-011 SHALL have port game_reset  output  1  one-cycle pulse that clears movement, score and asteroid positions.
REQ-012 SHALL have port death_sprite  output  1  selects the death dino image.
REQ-013 SHALL have port asteroid_on  output  3  per-slot asteroid enables.

Function
REQ-014 SHALL define press as: any btn bit high this cycle AND all btn bits low in the registered previous sample.
REQ-015 SHALL be a Moore FSM; all outputs SHALL be registered; state changes take effect one cycle after the qualifying input.
REQ-016 SHALL, in START on press, move to PLAY and assert game_reset for exactly the first PLAY cycle.
REQ-017 SHALL, in PLAY when collide_px=1, move to DYING on the next cycle; buttons SHALL be ignored in PLAY.
REQ-018 SHALL, in DYING, count frame_ticks in an 8-bit counter cleared on entry, and move to OVER on the cycle after the DEATH_FRAMES-th tick; presses SHALL be ignored.
REQ-019 SHALL, in OVER on press, move to START; game_reset SHALL NOT pulse on this transition.
REQ-020 SHALL, when debug=1 in any state, move to START next cycle, with priority over all other transitions and over spawn updates.
REQ-021 SHALL drive halt=1 in DYING and OVER, and 0 in START and PLAY.
REQ-022 SHALL drive death_sprite=1 in DYING and OVER only.
REQ-023 SHALL, in PLAY, count frame_ticks in an 8-bit spawn counter.
REQ-024 SHALL, when the spawn counter equals SPAWN_FRAMES-1 and frame_tick=1, wrap the counter to 0 and shift a 1 into asteroid_on LSB (000->001->011->111).
REQ-025 SHALL saturate asteroid_on at 111.
REQ-026 SHALL clear asteroid_on and the spawn counter in START and on the game_reset cycle.
REQ-027 SHALL hold asteroid_on and the spawn counter frozen in DYING and OVER.
REQ-028 SHALL, when collide_px and frame_tick coincide in PLAY, take the collision and leave spawn state unchanged.
REQ-029 SHALL, when press and debug coincide in OVER, go to START via debug; the outcome is identical to press alone.

Reset
REQ-030 SHALL, on reset, set: game_state=START, halt=0, game_reset=0, death_sprite=0, asteroid_on=000, both counters=0.
REQ-031 SHALL set the btn previous sample to 1111 on reset, so a button held through reset is not a press.
REQ-032 SHALL give reset priority over debug and all other inputs, including reset asserted mid-DYING or mid-spawn interval.

Structure
REQ-033 SHALL take state encodings, NUM_SLOTS=3 and counter width 8 from a shared package game_pkg.
REQ-034 SHALL implement press detection in one sub-module btn_edge (registered previous sample plus press pulse); all other logic stays in game_sequencer.

Verification
REQ-035 SHALL cover: reset with btn=0001 held, then release and press leftbtn -> START until the fresh press; game_state=1 and game_reset=1 for one cycle, 2 cycles after the press edge.
REQ-036 SHALL cover: PLAY with SPAWN_FRAMES=4 and 20 frame_ticks -> asteroid_on goes 001 at tick 4, 011 at tick 8, 111 at tick 12, and stays 111.
REQ-037 SHALL cover: collide_px pulse for 1 cycle coincident with frame_tick -> next cycle game_state=3, halt=1, death_sprite=1, asteroid_on unchanged.
REQ-038 SHALL cover: DEATH_FRAMES=3 in DYING, with presses injected -> game_state=2 one cycle after the 3rd tick; presses have no effect.
REQ-039 SHALL cover: OVER, press downbtn -> game_state=0, halt=0, asteroid_on=000, no game_reset pulse.
REQ-040 SHALL cover: debug=1 asserted mid-PLAY with asteroid_on=011 -> next cycle game_state=0, asteroid_on=000; reset asserted the same cycle as debug -> reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encoding, slot count and counter width.
package game_pkg;

  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {
    StStart = 2'd0,
    StPlay  = 2'd1,
    StOver  = 2'd2,
    StDying = 2'd3
  } game_state_e;

endpackage

// File: rtl/btn_edge.sv
// Registered press detector: a press is any button high after a sample with all buttons low.
module btn_edge (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_btn,
  output logic       o_press
);

  logic [3:0] r_prev;
  logic       r_press;

  // Previous sample resets to all-ones so a button held through reset never counts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev  <= 4'hF;
      r_press <= 1'b0;
    end else begin
      r_prev  <= i_btn;
      r_press <= (|i_btn) & ~(|r_prev);
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/game_sequencer.sv
// Game flow FSM (START/PLAY/DYING/OVER) with death timer and asteroid slot spawning.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned SPAWN_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           btn,
  input  logic                 debug,
  input  logic                 frame_tick,
  input  logic                 collide_px,
  output logic [1:0]           game_state,
  output logic                 halt,
  output logic                 game_reset,
  output logic                 death_sprite,
  output logic [NUM_SLOTS-1:0] asteroid_on
);

  localparam logic [CNT_W-1:0] DeathLast = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] SpawnLast = CNT_W'(SPAWN_FRAMES - 1);

  game_state_e          r_state, w_state_d;
  logic [CNT_W-1:0]     r_death_cnt, w_death_d;
  logic [CNT_W-1:0]     r_spawn_cnt, w_spawn_d;
  logic [NUM_SLOTS-1:0] r_ast, w_ast_d;
  logic                 r_game_reset, w_grst_d;
  logic                 r_halt, r_death_sprite;
  logic                 w_press;

  btn_edge u_btn_edge (
    .i_clk   (clk),
    .i_reset (reset),
    .i_btn   (btn),
    .o_press (w_press)
  );

  always_comb begin
    w_state_d = r_state;
    w_death_d = r_death_cnt;
    w_spawn_d = r_spawn_cnt;
    w_ast_d   = r_ast;
    w_grst_d  = 1'b0;

    unique case (r_state)
      StStart: begin
        if (w_press) begin
          w_state_d = StPlay;
          w_grst_d  = 1'b1;
        end
      end
      StPlay: begin
        if (r_game_reset) begin
          w_spawn_d = '0;
          w_ast_d   = '0;
        end
        // Collision wins over a coincident frame tick; spawn state is left alone.
        if (collide_px) begin
          w_state_d = StDying;
          w_death_d = '0;
        end else if (frame_tick && !r_game_reset) begin
          if (r_spawn_cnt == SpawnLast) begin
            w_spawn_d = '0;
            w_ast_d   = {r_ast[NUM_SLOTS-2:0], 1'b1};
          end else begin
            w_spawn_d = r_spawn_cnt + 1'b1;
          end
        end
      end
      StDying: begin
        if (frame_tick) begin
          if (r_death_cnt == DeathLast) begin
            w_state_d = StOver;
          end else begin
            w_death_d = r_death_cnt + 1'b1;
          end
        end
      end
      StOver: begin
        if (w_press) begin
          w_state_d = StStart;
        end
      end
      default: w_state_d = StStart;
    endcase

    if (debug) begin
      w_state_d = StStart;
      w_grst_d  = 1'b0;
    end

    // Entering or staying in START always leaves the spawn state cleared.
    if (w_state_d == StStart) begin
      w_spawn_d = '0;
      w_ast_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StStart;
      r_death_cnt    <= '0;
      r_spawn_cnt    <= '0;
      r_ast          <= '0;
      r_game_reset   <= 1'b0;
      r_halt         <= 1'b0;
      r_death_sprite <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_death_cnt    <= w_death_d;
      r_spawn_cnt    <= w_spawn_d;
      r_ast          <= w_ast_d;
      r_game_reset   <= w_grst_d;
      r_halt         <= (w_state_d == StDying) || (w_state_d == StOver);
      r_death_sprite <= (w_state_d == StDying) || (w_state_d == StOver);
    end
  end

  assign game_state   = r_state;
  assign halt         = r_halt;
  assign game_reset   = r_game_reset;
  assign death_sprite = r_death_sprite;
  assign asteroid_on  = r_ast;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues cycle-tagged expectations, monitor checks.
module tb_game_sequencer;

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_OVER  = 2'd2;
  localparam logic [1:0] S_DYING = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       debug;
  logic       frame_tick;
  logic       collide_px;
  logic [1:0] game_state;
  logic       halt;
  logic       game_reset;
  logic       death_sprite;
  logic [2:0] asteroid_on;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] st;
    logic       h;
    logic       gr;
    logic       ds;
    logic [2:0] ast;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  game_sequencer #(
    .DEATH_FRAMES (3),
    .SPAWN_FRAMES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .debug        (debug),
    .frame_tick   (frame_tick),
    .collide_px   (collide_px),
    .game_state   (game_state),
    .halt         (halt),
    .game_reset   (game_reset),
    .death_sprite (death_sprite),
    .asteroid_on  (asteroid_on)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc ||
            {game_state, halt, game_reset, death_sprite, asteroid_on} !==
            {sb[i].st, sb[i].h, sb[i].gr, sb[i].ds, sb[i].ast}) begin
          errors++;
          $display("FAIL %s @cyc %0d: got st=%0d halt=%0b grst=%0b death=%0b ast=%03b, want st=%0d halt=%0b grst=%0b death=%0b ast=%03b",
                   sb[i].name, cyc, game_state, halt, game_reset, death_sprite, asteroid_on,
                   sb[i].st, sb[i].h, sb[i].gr, sb[i].ds, sb[i].ast);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int dc, input string nm, input logic [1:0] st, input logic h,
                          input logic gr, input logic ds, input logic [2:0] a);
    exp_t e;
    e.cyc = cyc + dc; e.name = nm; e.st = st; e.h = h; e.gr = gr; e.ds = ds; e.ast = a;
    sb.push_back(e);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // Press leftbtn from START; PLAY with game_reset lands two cycles after the edge.
  task automatic start_game(input string nm);
    btn = 4'b0001;
    push_exp(1, {nm, "_wait"},  S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    push_exp(2, {nm, "_grst"},  S_PLAY,  1'b0, 1'b1, 1'b0, 3'b000);
    push_exp(3, {nm, "_play"},  S_PLAY,  1'b0, 1'b0, 1'b0, 3'b000);
    step();
    btn = 4'b0000;
    step();
    step();
  endtask

  logic [2:0] spawn_tab [20] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001,
                                 3'b011, 3'b011, 3'b011, 3'b011, 3'b111, 3'b111, 3'b111,
                                 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; btn = 4'b0001; debug = 1'b0; frame_tick = 1'b0; collide_px = 1'b0;
    step();
    step();
    push_exp(0, "reset_vals", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    step();

    // Button held through reset is not a press.
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) push_exp(i, "held_btn", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (4) step();
    btn = 4'b0000;
    push_exp(1, "released", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    step();
    start_game("g1");

    for (int k = 0; k < 20; k++) begin
      push_exp(1, $sformatf("spawn_t%0d", k + 1), S_PLAY, 1'b0, 1'b0, 1'b0, spawn_tab[k]);
      tick();
    end

    // Collision coincident with a frame tick.
    collide_px = 1'b1; frame_tick = 1'b1;
    push_exp(1, "collide", S_DYING, 1'b1, 1'b0, 1'b1, 3'b111);
    step();
    collide_px = 1'b0; frame_tick = 1'b0;
    step();

    // DYING: presses are ignored, OVER one cycle after the third tick.
    for (int k = 1; k <= 3; k++) begin
      btn = 4'b0100;
      push_exp(1, "dying_press", S_DYING, 1'b1, 1'b0, 1'b1, 3'b111);
      step();
      btn = 4'b0000;
      push_exp(1, "dying_hold", S_DYING, 1'b1, 1'b0, 1'b1, 3'b111);
      step();
      if (k == 3) push_exp(1, "to_over", S_OVER, 1'b1, 1'b0, 1'b1, 3'b111);
      else        push_exp(1, "dying_tick", S_DYING, 1'b1, 1'b0, 1'b1, 3'b111);
      tick();
    end
    push_exp(1, "over_hold", S_OVER, 1'b1, 1'b0, 1'b1, 3'b111);
    step();

    // OVER: press downbtn returns to START without a game_reset pulse.
    btn = 4'b1000;
    push_exp(1, "over_wait", S_OVER,  1'b1, 1'b0, 1'b1, 3'b111);
    push_exp(2, "over_exit", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    push_exp(3, "start_idle", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    btn = 4'b0000;
    repeat (3) step();

    // Debug mid-PLAY with two slots enabled.
    start_game("g2");
    repeat (9) tick();
    push_exp(0, "pre_debug", S_PLAY, 1'b0, 1'b0, 1'b0, 3'b011);
    debug = 1'b1;
    push_exp(1, "debug", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    debug = 1'b0;
    push_exp(1, "post_debug", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    step();

    // Collision without a tick, then reset and debug together mid-DYING.
    start_game("g3");
    repeat (2) tick();
    collide_px = 1'b1;
    push_exp(1, "collide2", S_DYING, 1'b1, 1'b0, 1'b1, 3'b000);
    step();
    collide_px = 1'b0;
    tick();
    reset = 1'b1; debug = 1'b1; btn = 4'b0010;
    push_exp(1, "reset_debug", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    reset = 1'b0; debug = 1'b0;
    push_exp(1, "after_reset", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    push_exp(2, "after_reset2", S_START, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    btn = 4'b0000;
    repeat (3) step();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expectations unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
